// File: rtl/oled_init_sequencer.sv
// Streams one I2C write (address, control byte, SSD1306 power-up list) into the
// byte transmitter through its enable/command/next/ack handshake.
//
// state       | meaning
// S_IDLE      | waiting for start, enable low
// S_WAIT_NEXT | byte presented, waiting for transmitter to finish it
// S_ACK_WAIT  | ack issued, waiting for next to drop before the following byte
// S_STOP      | enable low so the transmitter can issue its stop, then done
// S_FAULT     | enable low after trouble/timeout, then back to idle without done
module oled_init_sequencer #(
    parameter logic [7:0] DEV_ADDR       = 8'h78,
    parameter logic [7:0] CTRL_BYTE      = 8'h00,
    parameter int         STOP_CYCLES    = 8,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [4:0] byte_index,
    output logic       i2c_enable,
    output logic [7:0] i2c_command,
    input  logic       i2c_next,
    output logic       i2c_ack,
    input  logic       i2c_trouble
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int STP_W = $clog2(STOP_CYCLES + 1);
    localparam logic [4:0]       LAST_IDX = 5'd26;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STP_W-1:0] STP_LAST = STP_W'(STOP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_NEXT,
        S_ACK_WAIT,
        S_STOP,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [4:0]       idx_q, idx_d;
    logic             en_q, en_d;
    logic [7:0]       cmd_q, cmd_d;
    logic             ack_q, ack_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [STP_W-1:0] stp_q, stp_d;

    function automatic logic [7:0] rom_byte(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:    b = DEV_ADDR;
            5'd1:    b = CTRL_BYTE;
            5'd2:    b = 8'hAE;
            5'd3:    b = 8'hD5;
            5'd4:    b = 8'h80;
            5'd5:    b = 8'hA8;
            5'd6:    b = 8'h3F;
            5'd7:    b = 8'hD3;
            5'd8:    b = 8'h00;
            5'd9:    b = 8'h40;
            5'd10:   b = 8'h8D;
            5'd11:   b = 8'h14;
            5'd12:   b = 8'h20;
            5'd13:   b = 8'h00;
            5'd14:   b = 8'hA1;
            5'd15:   b = 8'hC8;
            5'd16:   b = 8'hDA;
            5'd17:   b = 8'h12;
            5'd18:   b = 8'h81;
            5'd19:   b = 8'hCF;
            5'd20:   b = 8'hD9;
            5'd21:   b = 8'hF1;
            5'd22:   b = 8'hDB;
            5'd23:   b = 8'h40;
            5'd24:   b = 8'hA4;
            5'd25:   b = 8'hA6;
            5'd26:   b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            idx_q   <= '0;
            en_q    <= 1'b0;
            cmd_q   <= '0;
            ack_q   <= 1'b0;
            tmo_q   <= '0;
            stp_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            cmd_q   <= cmd_d;
            ack_q   <= ack_d;
            tmo_q   <= tmo_d;
            stp_q   <= stp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        idx_d   = idx_q;
        en_d    = en_q;
        cmd_d   = cmd_q;
        ack_d   = 1'b0;
        tmo_d   = tmo_q;
        stp_d   = stp_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_NEXT;
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    idx_d   = '0;
                    en_d    = 1'b1;
                    cmd_d   = DEV_ADDR;
                    tmo_d   = '0;
                end
            end
            S_WAIT_NEXT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (i2c_trouble || tmo_q == TMO_LAST) begin
                    state_d = S_FAULT;
                    en_d    = 1'b0;
                    error_d = 1'b1;
                    stp_d   = '0;
                end else if (i2c_next) begin
                    if (idx_q != LAST_IDX) begin
                        state_d = S_ACK_WAIT;
                        idx_d   = idx_q + 5'd1;
                        cmd_d   = rom_byte(idx_q + 5'd1);
                        ack_d   = 1'b1;
                        tmo_d   = '0;
                    end else begin
                        state_d = S_STOP;
                        en_d    = 1'b0;
                        stp_d   = '0;
                    end
                end
            end
            S_ACK_WAIT: begin
                // a next level held across the ack must fall before it can count again
                tmo_d = tmo_q + TMO_W'(1);
                if (i2c_trouble || tmo_q == TMO_LAST) begin
                    state_d = S_FAULT;
                    en_d    = 1'b0;
                    error_d = 1'b1;
                    stp_d   = '0;
                end else if (!i2c_next) begin
                    state_d = S_WAIT_NEXT;
                end
            end
            S_STOP, S_FAULT: begin
                stp_d = stp_q + STP_W'(1);
                if (stp_q == STP_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = (state_q == S_STOP);
                    stp_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                en_d    = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy        = busy_q;
        done        = done_q;
        error       = error_q;
        byte_index  = idx_q;
        i2c_enable  = en_q;
        i2c_command = cmd_q;
        i2c_ack     = ack_q;
    end

endmodule

// File: tb/tb_oled_init_sequencer.sv
// Bench for oled_init_sequencer: a behavioural byte transmitter with randomized
// latencies drives the handshake; captured bytes and timings are checked against the expected stream.
module tb_oled_init_sequencer;

    localparam int STOP_CYCLES    = 8;
    localparam int TIMEOUT_CYCLES = 16;

    logic       clock = 1'b0;
    logic       reset_n, start, i2c_next, i2c_trouble;
    logic       busy, done, error, i2c_enable, i2c_ack;
    logic [4:0] byte_index;
    logic [7:0] i2c_command;

    int checks = 0;
    int errors = 0;

    int   lat_cfg = 2, hold_cfg = 0, cnt = 0, hold_left = 0;
    bit   never_next = 1'b0;
    bit   en_prev = 1'b0;
    logic [7:0] cmd_prev = 8'h00;
    int   cyc = 0, ack_pulses = 0, done_pulses = 0, next_events = 0;
    int   fall_cyc = 0, done_cyc = 0, viol_ack = 0, viol_cmd = 0;
    logic [7:0] byte_q[$];
    int         idx_q[$];

    logic [7:0] exp_bytes [27] = '{8'h78, 8'h00, 8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F,
                                   8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14, 8'h20, 8'h00,
                                   8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9,
                                   8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};

    oled_init_sequencer #(
        .DEV_ADDR      (8'h78),
        .CTRL_BYTE     (8'h00),
        .STOP_CYCLES   (STOP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .byte_index (byte_index),
        .i2c_enable (i2c_enable),
        .i2c_command(i2c_command),
        .i2c_next   (i2c_next),
        .i2c_ack    (i2c_ack),
        .i2c_trouble(i2c_trouble)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    // One clock: observe outputs just after the edge, then update the transmitter model.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (i2c_ack) ack_pulses++;
        if (i2c_ack && !i2c_next) viol_ack++;
        if (en_prev && i2c_enable && i2c_command !== cmd_prev && !i2c_ack) viol_cmd++;
        if (done) begin
            done_pulses++;
            done_cyc = cyc;
        end
        if (en_prev && !i2c_enable) fall_cyc = cyc;
        if (i2c_enable !== 1'b1) begin
            i2c_next  = 1'b0;
            cnt       = 0;
            hold_left = 0;
        end else if (!en_prev) begin
            cnt = lat_cfg;
        end else if (i2c_next) begin
            if (i2c_ack) hold_left = hold_cfg + 1;
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) begin
                    i2c_next = 1'b0;
                    cnt      = lat_cfg;
                end
            end
        end else if (!never_next) begin
            cnt--;
            if (cnt <= 0) begin
                i2c_next = 1'b1;
                next_events++;
                byte_q.push_back(i2c_command);
                idx_q.push_back(int'(byte_index));
            end
        end
        en_prev  = (i2c_enable === 1'b1);
        cmd_prev = i2c_command;
    endtask

    task automatic clear_model();
        byte_q.delete();
        idx_q.delete();
        ack_pulses  = 0;
        done_pulses = 0;
        next_events = 0;
        viol_ack    = 0;
        viol_cmd    = 0;
        fall_cyc    = 0;
        done_cyc    = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_idle(output bit ok);
        int n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b1;
        tick();
        tick();
        start = 1'b0;
        checks++;
        if ({busy, done, error, byte_index, i2c_enable, i2c_command, i2c_ack} !== 18'd0) begin
            errors++;
            $display("FAIL reset_values: busy=%b done=%b error=%b idx=%0d en=%b cmd=%h ack=%b, required all 0",
                     busy, done, error, byte_index, i2c_enable, i2c_command, i2c_ack);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || i2c_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_start: busy=%b en=%b, required 0 0", busy, i2c_enable);
        end
    endtask

    task automatic test_start();
        bit ok;
        clear_model();
        lat_cfg  = 6;
        hold_cfg = 0;
        pulse_start();
        checks++;
        if ({i2c_enable, busy, i2c_command, byte_index, i2c_ack} !== {1'b1, 1'b1, 8'h78, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL start_first_byte: en=%b busy=%b cmd=%h idx=%0d ack=%b, required 1 1 78 0 0",
                     i2c_enable, busy, i2c_command, byte_index, i2c_ack);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (i2c_ack !== 1'b0) begin
                errors++;
                $display("FAIL ack_before_next: cycle %0d ack=%b, required 0", i, i2c_ack);
            end
        end
        run_to_idle(ok);
        checks++;
        if (!ok || done_pulses != 1) begin
            errors++;
            $display("FAIL start_run_done: idle=%0b done_pulses=%0d, required 1 1", ok, done_pulses);
        end
    endtask

    task automatic test_full_run(input int lat, input int hold, input string tag);
        bit ok;
        int nbytes;
        clear_model();
        lat_cfg  = lat;
        hold_cfg = hold;
        pulse_start();
        run_to_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s idle_timeout: busy=%b, required 0", tag, busy);
        end
        nbytes = byte_q.size();
        checks++;
        if (nbytes != 27 || next_events != 27) begin
            errors++;
            $display("FAIL %s next_events: bytes=%0d events=%0d, required 27", tag, nbytes, next_events);
        end
        for (int i = 0; i < 27 && i < nbytes; i++) begin
            checks++;
            if (byte_q[i] !== exp_bytes[i] || idx_q[i] != i) begin
                errors++;
                $display("FAIL %s byte[%0d]: got %h at idx %0d, required %h at idx %0d",
                         tag, i, byte_q[i], idx_q[i], exp_bytes[i], i);
            end
        end
        checks++;
        if (ack_pulses != 26) begin
            errors++;
            $display("FAIL %s ack_count: got %0d, required 26", tag, ack_pulses);
        end
        checks++;
        if (done_pulses != 1 || done_cyc - fall_cyc != STOP_CYCLES) begin
            errors++;
            $display("FAIL %s done_timing: pulses=%0d delay=%0d, required 1 %0d",
                     tag, done_pulses, done_cyc - fall_cyc, STOP_CYCLES);
        end
        checks++;
        if (viol_ack != 0 || viol_cmd != 0 || error !== 1'b0) begin
            errors++;
            $display("FAIL %s handshake_rules: ack_wo_next=%0d cmd_changes=%0d error=%b, required 0 0 0",
                     tag, viol_ack, viol_cmd, error);
        end
    endtask

    task automatic test_next_hold();
        test_full_run(int'($urandom_range(1, 6)), 5, "next_hold");
    endtask

    task automatic test_trouble();
        bit ok;
        bit err_dropped = 1'b0;
        int n = 0;
        clear_model();
        lat_cfg  = $urandom_range(1, 4);
        hold_cfg = $urandom_range(0, 2);
        pulse_start();
        while (byte_index != 5'd10 && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (byte_index !== 5'd10) begin
            errors++;
            $display("FAIL trouble_reach_byte10: idx=%0d, required 10", byte_index);
        end
        i2c_trouble = 1'b1;
        tick();
        i2c_trouble = 1'b0;
        checks++;
        if (i2c_enable !== 1'b0 || error !== 1'b1 || i2c_ack !== 1'b0) begin
            errors++;
            $display("FAIL trouble_response: en=%b error=%b ack=%b, required 0 1 0", i2c_enable, error, i2c_ack);
        end
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
            if (error !== 1'b1) err_dropped = 1'b1;
        end
        checks++;
        if (n != STOP_CYCLES || err_dropped || done_pulses != 0) begin
            errors++;
            $display("FAIL trouble_recovery: busy_low_after=%0d err_dropped=%0b done=%0d, required %0d 0 0",
                     n, err_dropped, done_pulses, STOP_CYCLES);
        end
        clear_model();
        pulse_start();
        checks++;
        if ({error, byte_index, i2c_command, i2c_enable} !== {1'b0, 5'd0, 8'h78, 1'b1}) begin
            errors++;
            $display("FAIL trouble_restart: error=%b idx=%0d cmd=%h en=%b, required 0 0 78 1",
                     error, byte_index, i2c_command, i2c_enable);
        end
        run_to_idle(ok);
        checks++;
        if (!ok || done_pulses != 1 || byte_q.size() != 27) begin
            errors++;
            $display("FAIL trouble_rerun: idle=%0b done=%0d bytes=%0d, required 1 1 27",
                     ok, done_pulses, byte_q.size());
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n = 0;
        clear_model();
        never_next = 1'b1;
        pulse_start();
        while (error !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != TIMEOUT_CYCLES || i2c_enable !== 1'b0) begin
            errors++;
            $display("FAIL timeout_error: error after %0d cycles en=%b, required %0d 0",
                     n, i2c_enable, TIMEOUT_CYCLES);
        end
        run_to_idle(ok);
        never_next = 1'b0;
        checks++;
        if (!ok || done_pulses != 0 || error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_no_done: idle=%0b done=%0d error=%b, required 1 0 1", ok, done_pulses, error);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0;
        int bad = 0;
        clear_model();
        lat_cfg  = $urandom_range(1, 5);
        hold_cfg = $urandom_range(0, 3);
        pulse_start();
        while (byte_index != 5'd12 && n < 1000) begin
            tick();
            n++;
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if ({busy, done, error, byte_index, i2c_enable, i2c_command, i2c_ack} !== 18'd0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b error=%b idx=%0d en=%b cmd=%h ack=%b, required all 0",
                     busy, done, error, byte_index, i2c_enable, i2c_command, i2c_ack);
        end
        reset_n = 1'b1;
        tick();
        clear_model();
        pulse_start();
        checks++;
        if (i2c_command !== 8'h78 || byte_index !== 5'd0) begin
            errors++;
            $display("FAIL replay_start: cmd=%h idx=%0d, required 78 0", i2c_command, byte_index);
        end
        n = 0;
        while (byte_index < 5'd3 && n < 1000) begin
            tick();
            n++;
        end
        pulse_start();
        checks++;
        if (busy !== 1'b1 || byte_index < 5'd3) begin
            errors++;
            $display("FAIL start_while_busy: busy=%b idx=%0d, required 1 and idx>=3", busy, byte_index);
        end
        run_to_idle(ok);
        for (int i = 0; i < byte_q.size() && i < 27; i++)
            if (byte_q[i] !== exp_bytes[i]) bad++;
        checks++;
        if (!ok || byte_q.size() != 27 || bad != 0 || done_pulses != 1) begin
            errors++;
            $display("FAIL replay_sequence: idle=%0b bytes=%0d wrong=%0d done=%0d, required 1 27 0 1",
                     ok, byte_q.size(), bad, done_pulses);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        i2c_next    = 1'b0;
        i2c_trouble = 1'b0;
        test_reset();
        test_start();
        test_full_run(1, 0, "run_fast");
        for (int r = 0; r < 3; r++)
            test_full_run(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), "run_random");
        test_next_hold();
        test_trouble();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/oled_init_sequencer.md
Name: oled_init_sequencer

Overview:
- Upstream feeder for the I2C byte transmitter that drives the OLED panel.
- On a start pulse it streams one complete I2C write transaction through the transmitter's enable/command/next/ack handshake: device address byte, control byte 0x00, then the fixed SSD1306 power-up command list.
- Raises done when the transaction completes. Raises error on transmitter trouble or a byte timeout.

Parameters:
- DEV_ADDR, 8'h78, address byte sent first (7-bit 0x3C, write bit 0).
- CTRL_BYTE, 8'h00, control byte sent second (command stream, Co=0).
- STOP_CYCLES, 8, cycles enable is held low after the last byte so the transmitter can complete its stop condition.
- TIMEOUT_CYCLES, 4096, maximum cycles allowed in WAIT_NEXT for one byte before error.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to run the sequence; ignored unless in IDLE.
- busy  output  1  high from the cycle after an accepted start until done/error.
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  sticky fault flag; cleared by the next accepted start or by reset.
- byte_index  output  5  index of the byte currently presented, 0..26.
- i2c_enable  output  1  transmitter enable; high for the whole transaction.
- i2c_command  output  8  byte to transmit; stable from presentation until the following i2c_next.
- i2c_next  input  1  transmitter has finished the current byte and waits for ack.
- i2c_ack  output  1  one-cycle pulse meaning "next byte is on i2c_command, send it".
- i2c_trouble  input  1  transmitter fault indication.

Behaviour:
- Reset (reset_n=0 at an edge):
  - Outputs: busy=0, done=0, error=0, byte_index=0, i2c_enable=0, i2c_command=0x00, i2c_ack=0.
  - State goes to IDLE; timeout and stop counters cleared.
  - Mid-transaction reset drops i2c_enable on that edge. The transmitter issues its own stop.
- Byte stream (27 bytes, index 0..26):
  - Index 0: DEV_ADDR. Index 1: CTRL_BYTE.
  - Index 2..26: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF.
  - The list is a fixed internal ROM.
- IDLE:
  - On start=1: byte_index=0, i2c_command=DEV_ADDR, i2c_enable=1, busy=1, error=0, all on the next edge. Go to WAIT_NEXT.
- WAIT_NEXT:
  - The timeout counter increments each cycle.
  - If i2c_trouble=1: go to FAULT. This has priority over i2c_next.
  - Else if the counter reaches TIMEOUT_CYCLES: go to FAULT.
  - Else if i2c_next=1 and byte_index<26: byte_index+1, i2c_command=ROM[byte_index+1], i2c_ack=1 for exactly one cycle, counter cleared. Go to ACK_WAIT.
  - Else if i2c_next=1 and byte_index=26: i2c_enable=0, stop counter cleared. Go to STOP.
- ACK_WAIT:
  - i2c_ack=0. Wait for i2c_next=0, then go to WAIT_NEXT. This blocks double-counting one next level.
  - i2c_trouble=1 here goes to FAULT.
  - The timeout counter also runs here.
- STOP:
  - i2c_enable=0 for STOP_CYCLES cycles.
  - Then: done=1 for one cycle, busy=0, go to IDLE.
- FAULT:
  - i2c_enable=0, i2c_ack=0, error=1 (sticky).
  - Enter STOP-length wait, then busy=0 and go to IDLE without a done pulse.
- Hold rules:
  - i2c_command never changes while i2c_enable=1, except on the ack cycle.
  - i2c_ack is never asserted while i2c_next=0.
- Simultaneous events:
  - start while busy: ignored.
  - start on the same edge as reset_n=0: reset wins.

Test Plan:
- Reset then start pulse at cycle T -> at T+1: i2c_enable=1, i2c_command=0x78, busy=1, byte_index=0; i2c_ack stays 0 until the first i2c_next.
- Full run with a behavioural transmitter model (next raised a fixed latency after enable or ack, cleared on ack) -> exactly 27 next events and 26 ack pulses; the captured byte sequence is 78 00 AE D5 … A6 AF; done pulses once, STOP_CYCLES after i2c_enable falls.
- i2c_next held high 5 cycles after ack -> byte_index advances by exactly 1 per next rising edge; no extra ack pulses.
- i2c_trouble pulsed during byte 10 -> i2c_enable=0 next edge, error=1 held, no done, busy=0 after STOP_CYCLES; the next start clears error and restarts from byte 0.
- Model never raises next (TIMEOUT_CYCLES=16) -> error=1 after 16 cycles in WAIT_NEXT; i2c_enable low.
- reset_n=0 for one cycle at byte 12 -> all outputs at reset values on that edge; start afterwards replays from DEV_ADDR. A start issued while busy has no effect on byte_index.
